// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester handshakes plus the single regfile access port.
// lock0/lock1 exist only when REGFILE_ARB_LOCK_EN is defined.
interface regfile_arbiter_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
  logic              req0, req1, we0, we1, ack0, ack1;
  logic [ADDR_W-1:0] addr0, addr1, rf_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, rf_d_in, rf_d_out;
  logic              rf_we_;
`ifdef REGFILE_ARB_LOCK_EN
  logic              lock0, lock1;
`endif
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_d_out,
`ifdef REGFILE_ARB_LOCK_EN
    output lock0, lock1,
`endif
    input  ack0, ack1, rdata0, rdata1, rf_addr, rf_d_in, rf_we_
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_d_out,
`ifdef REGFILE_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    output ack0, ack1, rdata0, rdata1, rf_addr, rf_d_in, rf_we_
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester round-robin sequencer for a single-port regfile.
// Define REGFILE_ARB_LOCK_EN to let the current owner hold the grant with lock0/lock1.
module regfile_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  regfile_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q;
  logic              gnt_q, last_q, gnt_d, go, keep;
  logic [1:0]        req, we, ack_q;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_d_in_q;
  logic              rf_we_q;
  assign req      = {bus.req1, bus.req0};
  assign we       = {bus.we1, bus.we0};
  assign addr[0]  = bus.addr0;
  assign addr[1]  = bus.addr1;
  assign wdata[0] = bus.wdata0;
  assign wdata[1] = bus.wdata1;
`ifdef REGFILE_ARB_LOCK_EN
  assign keep = (state_q == DONE) && (gnt_q ? bus.lock1 & bus.req1 : bus.lock0 & bus.req0);
`else
  assign keep = 1'b0;
`endif
  // In DONE the served request is consumed, so only the other side can win unless locked.
  always_comb begin
    gnt_d = keep ? gnt_q : (state_q == DONE) ? ~gnt_q : (req == 2'b11) ? ~last_q : req[1];
    go    = keep || ((state_q == DONE) ? req[~gnt_q] : |req);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      ack_q     <= '0;
      rdata_q   <= '{default: '0};
      rf_addr_q <= '0;
      rf_d_in_q <= '0;
      rf_we_q   <= 1'b1;
    end else begin
      ack_q     <= '0;
      rf_addr_q <= '0;
      rf_d_in_q <= '0;
      rf_we_q   <= 1'b1;
      if (state_q == ACCESS) begin
        state_q        <= DONE;
        last_q         <= gnt_q;
        ack_q[gnt_q]   <= 1'b1;
        rdata_q[gnt_q] <= we[gnt_q] ? wdata[gnt_q] : bus.rf_d_out;
      end else if (go) begin
        state_q   <= ACCESS;
        gnt_q     <= gnt_d;
        rf_addr_q <= addr[gnt_d];
        rf_d_in_q <= wdata[gnt_d];
        rf_we_q   <= ~we[gnt_d];
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];
  assign bus.rf_addr = rf_addr_q;
  assign bus.rf_d_in = rf_d_in_q;
  assign bus.rf_we_  = rf_we_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and randomized checks of regfile_arbiter against a behavioural regfile and scoreboard.
module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] rf_mem [32];
  logic [31:0] shadow [32];
  regfile_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  regfile_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rf_d_out = rf_mem[bus.rf_addr];
  always @(posedge clk) if (bus.rf_we_ === 1'b0) rf_mem[bus.rf_addr] <= bus.rf_d_in;

  task automatic idle_inputs;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
`ifdef REGFILE_ARB_LOCK_EN
    bus.lock0 = 0; bus.lock1 = 0;
`endif
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  // One isolated transaction from IDLE; lat is negedges from issue until ack is seen.
  task automatic single(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    lat = 0;
    @(negedge clk);
    if (r) begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    do begin @(negedge clk); lat++; end while (!(r ? bus.ack1 : bus.ack0) && lat < 10);
    rd = r ? bus.rdata1 : bus.rdata0;
    if (r) bus.req1 = 0; else bus.req0 = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.rf_addr, bus.rf_d_in, bus.rf_we_} !== {2'b00, 64'd0, 5'd0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values got ack=%b%b rd0=%h rd1=%h addr=%h din=%h we_=%b want all 0, we_=1",
               bus.ack1, bus.ack0, bus.rdata0, bus.rdata1, bus.rf_addr, bus.rf_d_in, bus.rf_we_);
    end
    reset = 0;
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1, bus.rf_we_} !== 3'b001) begin
      miscompares++; $display("FAIL reset_idle got ack=%b%b we_=%b want 00 1", bus.ack1, bus.ack0, bus.rf_we_);
    end
  endtask

  task automatic test_write_read;
    apply_reset();
    @(negedge clk); bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 32'hA5;
    @(negedge clk);
    vectors++;
    if ({bus.rf_we_, bus.rf_addr, bus.rf_d_in, bus.ack0} !== {1'b0, 5'd3, 32'hA5, 1'b0}) begin
      miscompares++; $display("FAIL wr_access got we_=%b addr=%0d din=%h ack0=%b want 0 3 a5 0", bus.rf_we_, bus.rf_addr, bus.rf_d_in, bus.ack0);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.rdata0, bus.rf_we_, bus.rf_addr, bus.rf_d_in} !== {1'b1, 32'hA5, 1'b1, 5'd0, 32'd0}) begin
      miscompares++; $display("FAIL wr_done got ack0=%b rd0=%h we_=%b addr=%0d din=%h want 1 a5 1 0 0", bus.ack0, bus.rdata0, bus.rf_we_, bus.rf_addr, bus.rf_d_in);
    end
    bus.we0 = 0;
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.rf_we_, bus.rf_addr} !== {1'b0, 1'b1, 5'd0}) begin
      miscompares++; $display("FAIL rd_idle got ack0=%b we_=%b addr=%0d want 0 1 0", bus.ack0, bus.rf_we_, bus.rf_addr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rf_we_, bus.rf_addr, bus.ack0} !== {1'b1, 5'd3, 1'b0}) begin
      miscompares++; $display("FAIL rd_access got we_=%b addr=%0d ack0=%b want 1 3 0", bus.rf_we_, bus.rf_addr, bus.ack0);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.rdata0} !== {1'b1, 32'hA5}) begin
      miscompares++; $display("FAIL rd_done got ack0=%b rd0=%h want 1 a5", bus.ack0, bus.rdata0);
    end
    bus.req0 = 0;
  endtask

  task automatic test_tie;
    logic [31:0] rd;
    int lat;
    apply_reset();
    single(1, 1, 1, 32'h11, rd, lat);
    single(1, 1, 2, 32'h22, rd, lat);
    vectors++;
    if (rd !== 32'h22 || lat != 2) begin
      miscompares++; $display("FAIL tie_preload got rd=%h lat=%0d want 22 2", rd, lat);
    end
    apply_reset();
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
    @(negedge clk);
    vectors++;
    if (bus.rf_addr !== 5'd1) begin
      miscompares++; $display("FAIL tie_first_addr got %0d want 1", bus.rf_addr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1, bus.rdata0} !== {2'b10, 32'h11}) begin
      miscompares++; $display("FAIL tie_ack0 got ack0=%b ack1=%b rd0=%h want 1 0 11", bus.ack0, bus.ack1, bus.rdata0);
    end
    bus.req0 = 0;
    @(negedge clk);
    vectors++;
    if ({bus.rf_addr, bus.ack0, bus.ack1} !== {5'd2, 2'b00}) begin
      miscompares++; $display("FAIL tie_second_addr got addr=%0d ack=%b%b want 2 00", bus.rf_addr, bus.ack1, bus.ack0);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ack1, bus.ack0, bus.rdata1} !== {2'b10, 32'h22}) begin
      miscompares++; $display("FAIL tie_ack1 got ack1=%b ack0=%b rd1=%h want 1 0 22", bus.ack1, bus.ack0, bus.rdata1);
    end
    bus.req1 = 0;
  endtask

  task automatic test_back_to_back;
    int order[$];
    int n0 = 0, n1 = 0, cyc = 0, last_ack = 0;
    apply_reset();
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
    while ((n0 < 4 || n1 < 4) && cyc < 40) begin
      @(negedge clk); cyc++;
      if (bus.ack0) begin order.push_back(0); n0++; last_ack = cyc; if (n0 == 4) bus.req0 = 0; end
      if (bus.ack1) begin order.push_back(1); n1++; last_ack = cyc; if (n1 == 4) bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    vectors++;
    if (order.size() != 8 || last_ack != 16) begin
      miscompares++; $display("FAIL b2b_span got acks=%0d last_ack_cycle=%0d want 8 16", order.size(), last_ack);
    end
    foreach (order[i]) begin
      vectors++;
      if (order[i] != i % 2) begin
        miscompares++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_in_access;
    logic [31:0] rd;
    int lat;
    apply_reset();
    single(0, 1, 5, 32'h55, rd, lat);
    @(negedge clk); bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5; bus.wdata0 = 32'hFF;
    @(negedge clk);
    vectors++;
    if (bus.rf_we_ !== 1'b0) begin
      miscompares++; $display("FAIL rst_access_pre got we_=%b want 0", bus.rf_we_);
    end
    reset = 1;
    #1;
    vectors++;
    if ({bus.rf_we_, bus.rf_addr, bus.rf_d_in} !== {1'b1, 5'd0, 32'd0}) begin
      miscompares++; $display("FAIL rst_access_async got we_=%b addr=%0d din=%h want 1 0 0", bus.rf_we_, bus.rf_addr, bus.rf_d_in);
    end
    bus.req0 = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      miscompares++; $display("FAIL rst_access_noack got ack=%b%b want 00", bus.ack1, bus.ack0);
    end
    single(0, 0, 5, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h55 || lat != 2) begin
      miscompares++; $display("FAIL rst_access_readback got rd=%h lat=%0d want 55 2", rd, lat);
    end
  endtask

  task automatic test_reset_in_done;
    apply_reset();
    @(negedge clk); bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({bus.ack1, bus.rdata1} !== {1'b1, 32'h55}) begin
      miscompares++; $display("FAIL rst_done_pre got ack1=%b rd1=%h want 1 55", bus.ack1, bus.rdata1);
    end
    reset = 1;
    #1;
    vectors++;
    if ({bus.ack1, bus.rdata1} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL rst_done_truncate got ack1=%b rd1=%h want 0 0", bus.ack1, bus.rdata1);
    end
    bus.req1 = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_sweep;
    logic [31:0] rd;
    int lat;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      single(1, 1, i[4:0], i, rd, lat);
      vectors++;
      if (rd !== i || lat != 2) begin
        miscompares++; $display("FAIL sweep_wr[%0d] got rd1=%h lat=%0d want %h 2", i, rd, lat, i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      single(0, 0, i[4:0], 32'h0, rd, lat);
      vectors++;
      if (rd !== i || lat != 2) begin
        miscompares++; $display("FAIL sweep_rd[%0d] got rd0=%h lat=%0d want %h 2", i, rd, lat, i);
      end
    end
  endtask

  // Scoreboard: data from a shadow memory applied in ack order, plus wait-time and fairness bounds.
  task automatic test_random;
    bit          pend [2], pw [2];
    logic [4:0]  pa [2];
    logic [31:0] pd [2], rd [2], expv;
    int          age [2], waited [2];
    logic [1:0]  ack;
    apply_reset();
    for (int i = 0; i < 32; i++) shadow[i] = i;
    for (int n = 0; n < 2; n++) begin pend[n] = 0; age[n] = 0; waited[n] = 0; end
    for (int c = 0; c < 430; c++) begin
      @(negedge clk);
      ack = {bus.ack1, bus.ack0};
      rd[0] = bus.rdata0; rd[1] = bus.rdata1;
      for (int n = 0; n < 2; n++) if (pend[n]) age[n]++;
      vectors++;
      if (ack == 2'b11) begin
        miscompares++; $display("FAIL rand_dual_ack at cycle %0d got 11 want at most one", c);
      end
      for (int n = 0; n < 2; n++) if (ack[n]) begin
        vectors++;
        expv = pw[n] ? pd[n] : shadow[pa[n]];
        if (!pend[n] || rd[n] !== expv || age[n] > 5 || waited[n] > 1) begin
          miscompares++;
          $display("FAIL rand_ack%0d cycle %0d got rdata=%h pend=%0b age=%0d waited=%0d want %h 1 <=5 <=1",
                   n, c, rd[n], pend[n], age[n], waited[n], expv);
        end
        if (pw[n]) shadow[pa[n]] = pd[n];
        pend[n] = 0;
        if (pend[1-n]) waited[1-n]++;
      end
      for (int n = 0; n < 2; n++) begin
        if (pend[n] && age[n] > 12) begin
          miscompares++; $display("FAIL rand_timeout%0d got age=%0d want <=5", n, age[n]);
          pend[n] = 0;
        end
        if (!pend[n] && c < 400 && $urandom_range(0, 1) == 1) begin
          pend[n] = 1; age[n] = 0; waited[n] = 0;
          pw[n] = 1'($urandom_range(0, 1));
          pa[n] = 5'($urandom_range(0, 31));
          pd[n] = $urandom;
        end
      end
      bus.req0 = pend[0]; bus.we0 = pw[0]; bus.addr0 = pa[0]; bus.wdata0 = pd[0];
      bus.req1 = pend[1]; bus.we1 = pw[1]; bus.addr1 = pa[1]; bus.wdata1 = pd[1];
    end
    vectors++;
    if (pend[0] || pend[1]) begin
      miscompares++; $display("FAIL rand_drain got pending=%b%b want 00", pend[1], pend[0]);
    end
    idle_inputs();
  endtask

`ifdef REGFILE_ARB_LOCK_EN
  task automatic test_lock;
    int order[$];
    int n0 = 0, cyc = 0;
    bit got1 = 0;
    apply_reset();
    @(negedge clk); bus.req0 = 1; bus.lock0 = 1; bus.we0 = 0; bus.addr0 = 1;
    @(negedge clk); bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
    while (!got1 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (bus.ack0) begin order.push_back(0); n0++; if (n0 == 3) begin bus.req0 = 0; bus.lock0 = 0; end end
      if (bus.ack1) begin order.push_back(1); got1 = 1; bus.req1 = 0; end
    end
    idle_inputs();
    vectors++;
    if (order.size() != 4) begin
      miscompares++; $display("FAIL lock_count got %0d acks want 4", order.size());
    end
    foreach (order[i]) begin
      vectors++;
      if (order[i] != (i == 3 ? 1 : 0)) begin
        miscompares++; $display("FAIL lock_order[%0d] got %0d want %0d", i, order[i], (i == 3 ? 1 : 0));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_reset_in_access();
    test_reset_in_done();
    test_sweep();
    test_random();
`ifdef REGFILE_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester round-robin arbiter and sequencer for the single-port `regfile` block. It accepts independent read/write requests from two masters, serialises them onto the regfile's one access port, and returns read data with a one-cycle acknowledge. It sits directly in front of `regfile` and owns its `addr`, `d_in` and `we_` inputs.

## Interface
- `ADDR_W`, 5: regfile address width.
- `DATA_W`, 32: regfile data width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `req0` / `req1`  in  1  request from requester 0 / 1; held high until ack.
- `we0` / `we1`  in  1  1 = write, 0 = read; held stable while req is high.
- `addr0` / `addr1`  in  ADDR_W  target register.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse, registered.
- `rdata0` / `rdata1`  out  DATA_W  completion data, valid while ack is high and held afterwards.
- `rf_addr`  out  ADDR_W  to regfile `addr`.
- `rf_d_in`  out  DATA_W  to regfile `d_in`.
- `rf_we_`  out  1  to regfile `we_`, active-low.
- `rf_d_out`  in  DATA_W  from regfile `d_out`, combinational from `rf_addr`.

## Operation
- FSM states: IDLE, ACCESS, DONE. Internal signals: `gnt`, the 1-bit index of the current owner, and `last`, the index of the last requester served.
- IDLE: if any req is high, load `gnt`, go to ACCESS. Otherwise stay.
- Grant choice:
  - If only one req is high, grant it.
  - If both are high, grant `!last`.
- ACCESS:
  - Drive `rf_addr = addrN`.
  - Drive `rf_d_in = wdataN`.
  - Drive `rf_we_ = !weN`.
  - At the ending edge, the regfile commits any write.
  - At the same edge, `rdataN` loads `rf_d_out` for a read, or `wdataN` for a write.
  - Set `ackN`, update `last = gnt`, go to DONE.
- DONE:
  - `ackN` is high.
  - `rf_we_` is high.
  - `rf_addr`/`rf_d_in` return to 0.
  - The served requester's req is ignored on this edge, since it is consumed.
  - If the other req is high, grant it and go to ACCESS. Else go to IDLE.
- Outside ACCESS: `rf_we_` is 1 and `rf_addr`/`rf_d_in` are 0.
- Requester rule: deassert req on the edge after ack is seen, or keep it high to queue another transaction. A new transaction is accepted no earlier than the cycle after DONE.

## Timing
- Reset values:
  - State: IDLE.
  - `last`: 1, so requester 0 wins the first tie.
  - `ack0`/`ack1`: 0.
  - `rdata0`/`rdata1`: 0.
  - `rf_addr`/`rf_d_in`: 0.
  - `rf_we_`: 1.
- Latency: req sampled at edge k; ACCESS in cycle k+1; ack high in cycle k+2.
- Single-requester throughput: one transaction per 3 cycles.
- Alternating two-requester throughput: one per 2 cycles (DONE→ACCESS).
- Simultaneous req in IDLE: round-robin by `last`.
- Back-to-back contention: requesters alternate strictly, and neither waits more than one transaction.
- Reset asserted during ACCESS:
  - `rf_we_` goes to 1 immediately, without waiting for a clock edge. No write commits.
  - No ack is generated.
  - Requesters must reissue the transaction.
- Reset asserted during DONE: the ack pulse is truncated, and `rdata` clears to 0.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined:
  - Adds inputs `lock0`/`lock1`, 1 bit each.
  - If the served requester has both lock and req high in DONE, it is re-granted and goes directly to ACCESS, even if the other req is high.
  - `last` is not updated while lock holds ownership.
  - Lock is ignored when the requester does not own the grant.
- Undefined: no lock ports, and arbitration is pure round-robin as above.

## Test plan
- Reset, then req0 writes 0xA5 to reg 3 → `rf_we_` = 0 only in the ACCESS cycle; ack0 two cycles after req; a following req0 read of reg 3 returns `rdata0` = 0xA5.
- req0 and req1 both rise in IDLE (reads of regs 1 and 2, preloaded with 0x11 and 0x22) → ack0 with 0x11 first, then ack1 with 0x22 two cycles later.
- Both requesters hold req for 4 transactions each → ack order 0,1,0,1,… with no repeated grant; total 16 cycles after first ACCESS.
- Write each reg 0..31 with its index via req1, then read back via req0 → every `rdata0` equals the address.
- Assert reset in the ACCESS cycle of a write of 0xFF to reg 5 → `rf_we_` rises immediately, no ack; reg 5 reads back its prior value.
- With `REGFILE_ARB_LOCK_EN`: req0 holds lock0 for 3 transactions while req1 is pending → three ack0 pulses, then ack1.
